// File: rtl/hs_pkg.sv
// Shared definitions for the handshake-to-FIFO write arbiter: state encoding,
// default data width and the round-robin winner selection.
package hs_pkg;

    localparam int unsigned HS_DW = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StWrite = ST_WRITE,
        StAck   = ST_ACK
    } hs_state_e;

    // Single active requester wins; on a tie the one not served last wins.
    function automatic logic pick_winner(input logic r0, input logic r1, input logic last_gnt);
        logic w;
        if (r0 && r1) begin
            w = ~last_gnt;
        end else begin
            w = r1;
        end
        return w;
    endfunction

endpackage

// File: rtl/hs_sync.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module hs_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the input through two flops to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hs_fifo_wr_arb.sv
// Round-robin arbiter joining two 4-phase bundled-data requesters onto one
// synchronous FIFO write port. One FIFO write per handshake, ack held until
// the requester releases its request.
// Build option: define HS_SYNC_EN to pass req0/req1 through 2-flop
// synchronizers (adds 2 cycles of request and release latency).
module hs_fifo_wr_arb
    import hs_pkg::*;
#(
    parameter int unsigned DW = HS_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    output logic          ack0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    output logic          ack1,
    input  logic          fifo_full,
    output logic          wr_en,
    output logic [DW-1:0] wr_data,
    output logic          busy
);

    logic      req0_s;
    logic      req1_s;
    hs_state_e state;
    logic      gnt;
    logic      last_gnt;
    logic      winner;
    logic      gnt_req;

`ifdef HS_SYNC_EN
    hs_sync u_sync_req0 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req0),
        .q     (req0_s)
    );

    hs_sync u_sync_req1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req1),
        .q     (req1_s)
    );
`else
    assign req0_s = req0;
    assign req1_s = req1;
`endif

    assign winner  = pick_winner(req0_s, req1_s, last_gnt);
    assign gnt_req = gnt ? req1_s : req0_s;

    // Handshake FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    // The write is committed here; a later fifo_full cannot cancel it.
                    if ((req0_s || req1_s) && !fifo_full) begin
                        gnt     <= winner;
                        wr_data <= winner ? data1 : data0;
                        wr_en   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= StWrite;
                    end
                end
                StWrite: begin
                    wr_en    <= 1'b0;
                    last_gnt <= gnt;
                    if (gnt) begin
                        ack1 <= 1'b1;
                    end else begin
                        ack0 <= 1'b1;
                    end
                    state <= StAck;
                end
                StAck: begin
                    // Release phase: a request already dropped gives a 1-cycle ack pulse.
                    if (!gnt_req) begin
                        ack0  <= 1'b0;
                        ack1  <= 1'b0;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: begin
                    wr_en <= 1'b0;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_fifo_wr_arb.sv
// Directed bench for hs_fifo_wr_arb. Expected write data is queued when a
// request is raised and popped by a monitor whenever wr_en is seen.
module tb_hs_fifo_wr_arb;

    localparam int DW = 8;
`ifdef HS_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          req0;
    logic [DW-1:0] data0;
    logic          ack0;
    logic          req1;
    logic [DW-1:0] data1;
    logic          ack1;
    logic          fifo_full;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    hs_fifo_wr_arb #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .data0     (data0),
        .ack0      (ack0),
        .req1      (req1),
        .data1     (data1),
        .ack1      (ack1),
        .fifo_full (fifo_full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // sel: 0 = ack0, 1 = ack1, 2 = wr_en
    task automatic wait_for(input int sel, input logic val, input string tag, input int budget);
        logic hit;
        logic s;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            s   = (sel == 0) ? ack0 : ((sel == 1) ? ack1 : wr_en);
            hit = (s === val);
        end
        check1(tag, hit, 1'b1);
    endtask

    // Both requesters raise together and release as soon as they see ack.
    task automatic contend_round(input int round);
        data0 = 8'h11;
        data1 = 8'h22;
        req0  = 1'b1;
        req1  = 1'b1;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
            if (!req0 && !req1 && !ack0 && !ack1 && !busy) break;
        end
        check1($sformatf("contend_done_%0d", round), busy | req0 | req1, 1'b0);
    endtask

    // Scoreboard: every write must match the oldest expected data.
    always @(negedge clk) begin
        if (rst_n) begin
            check1("ack_exclusive", ack0 & ack1, 1'b0);
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check1("unexpected_wr", wr_en, 1'b0);
                end else begin
                    check8("wr_data", wr_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req0      = 1'b1;
        data0     = 8'h77;
        req1      = 1'b0;
        data1     = '0;
        fifo_full = 1'b0;

        // Reset with a request pending.
        repeat (3) @(negedge clk);
        check1("rst_ack0", ack0, 1'b0);
        check1("rst_ack1", ack1, 1'b0);
        check1("rst_wr_en", wr_en, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check8("rst_wr_data", wr_data, 8'h00);
        rst_n = 1'b1;
        exp_q.push_back(8'h77);
        for (int i = 0; i < SL; i++) begin
            @(negedge clk);
            check1("rst_sync_lat", wr_en, 1'b0);
        end
        @(negedge clk);
        check1("rst_first_wr", wr_en, 1'b1);
        check1("rst_first_busy", busy, 1'b1);
        @(negedge clk);
        check1("rst_first_ack0", ack0, 1'b1);
        req0 = 1'b0;
        wait_for(0, 1'b0, "rst_ack0_release", 10);
        check1("rst_idle_busy", busy, 1'b0);

        // Single transfer with exact latency.
        @(negedge clk);
        data0 = 8'hA5;
        req0  = 1'b1;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < SL; i++) begin
            @(negedge clk);
            check1("single_sync_lat", wr_en, 1'b0);
        end
        @(negedge clk);
        check1("single_wr_en", wr_en, 1'b1);
        check8("single_wr_data", wr_data, 8'hA5);
        check1("single_ack_early", ack0, 1'b0);
        @(negedge clk);
        check1("single_wr_once", wr_en, 1'b0);
        check1("single_ack0", ack0, 1'b1);
        @(negedge clk);
        check1("single_ack0_hold", ack0, 1'b1);
        req0 = 1'b0;
        for (int i = 0; i < SL; i++) begin
            @(negedge clk);
            check1("single_ack_sync_hold", ack0, 1'b1);
        end
        @(negedge clk);
        check1("single_ack0_drop", ack0, 1'b0);
        check1("single_busy_drop", busy, 1'b0);

        // FIFO full holds off requester 1.
        fifo_full = 1'b1;
        data1     = 8'hC3;
        req1      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check1("full_no_wr", wr_en, 1'b0);
            check1("full_no_ack1", ack1, 1'b0);
        end
        fifo_full = 1'b0;
        exp_q.push_back(8'hC3);
        wait_for(2, 1'b1, "full_release_wr", 10);
        @(negedge clk);
        check1("full_ack1", ack1, 1'b1);
        req1 = 1'b0;
        wait_for(1, 1'b0, "full_ack1_drop", 10);

        // Contention: requester 1 was served last, so 0 wins each round first.
        contend_round(0);
        contend_round(1);

        // Reset while ack0 is high.
        @(negedge clk);
        data0 = 8'h3C;
        req0  = 1'b1;
        exp_q.push_back(8'h3C);
        wait_for(0, 1'b1, "midrst_ack0_up", 10);
        rst_n = 1'b0;
        req0  = 1'b0;
        #1;
        check1("midrst_ack0_async", ack0, 1'b0);
        check1("midrst_busy_async", busy, 1'b0);
        check1("midrst_wr_async", wr_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check1("midrst_no_rewrite", wr_en, 1'b0);
        check1("midrst_idle", busy, 1'b0);
        data0 = 8'h5A;
        req0  = 1'b1;
        exp_q.push_back(8'h5A);
        wait_for(2, 1'b1, "midrst_restart_wr", 10);
        wait_for(0, 1'b1, "midrst_restart_ack", 10);
        req0 = 1'b0;
        wait_for(0, 1'b0, "midrst_restart_drop", 10);

        repeat (2) @(negedge clk);
        check8("scoreboard_empty", 8'(exp_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hs_fifo_wr_arb.md
Name: hs_fifo_wr_arb

Overview:
- Two-requester arbiter sharing one synchronous FIFO write port.
- Each requester uses a 4-phase bundled-data handshake (req/ack/data), the same signalling the team's Muller C-element pipeline stages produce.
- The block grants requesters round-robin, issues exactly one FIFO write per handshake, and returns ack.
- Sits between the C-element handshake front end and the FIFO storage/pointer logic.

Parameters:
- DW, 8, data width of each requester and of the FIFO write port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 4-phase request.
- data0  in  DW  requester 0 bundled data; stable while req0=1.
- ack0  out  1  requester 0 acknowledge.
- req1  in  1  requester 1 4-phase request.
- data1  in  DW  requester 1 bundled data; stable while req1=1.
- ack1  out  1  requester 1 acknowledge.
- fifo_full  in  1  FIFO full flag, synchronous to clk.
- wr_en  out  1  FIFO write enable, one cycle per transfer.
- wr_data  out  DW  FIFO write data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: ack0=0, ack1=0, wr_en=0, wr_data=0, busy=0, state=IDLE, last_gnt=1 (requester 0 wins the first tie).
- Inputs: reqN_s denotes the request as used by the FSM (raw or synchronized; see Optional Feature).
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - If (req0_s|req1_s) and !fifo_full: pick the winner, capture its data into wr_data, set wr_en=1, set gnt=winner, go to WRITE.
  - If fifo_full: stay in IDLE; no grant, no write.
- WRITE (exactly 1 cycle):
  - wr_en returns to 0.
  - ack[gnt] goes to 1.
  - last_gnt is updated to gnt.
  - Go to ACK.
- ACK:
  - Hold ack[gnt]=1 while req[gnt]_s=1.
  - When req[gnt]_s is sampled 0: ack[gnt] goes to 0 and the FSM returns to IDLE.
- Arbitration:
  - Only one requester active: it wins.
  - Both active: the requester != last_gnt wins.
  - The losing request stays pending and is served on the next IDLE with !fifo_full.
- Timing:
  - Latency: req sampled high at edge k -> wr_en=1 during cycle k..k+1 -> ack high after edge k+1.
  - Minimum 3 cycles per transfer when the requester responds instantly.
- Exactly one write per 4-phase cycle. A new req rise is only honoured after ack for that requester has returned to 0.
- fifo_full asserting while in WRITE or ACK does not cancel the transfer; the write was already committed at the IDLE->WRITE edge.
- Protocol violation (reqN dropping during WRITE): the write still completes, and ack pulses for 1 cycle in ACK.
- Reset mid-transfer: all outputs clear immediately (asynchronous). Any wr_en in flight is lost; the requester sees ack=0 and must restart.
- ack0 and ack1 are never high simultaneously. wr_en is never high while fifo_full was sampled 1 at the grant edge.

Optional Feature:
- Macro: HS_SYNC_EN.
- Defined: req0/req1 each pass through a 2-flop synchronizer (reset 0) before the FSM. This adds 2 cycles of request-to-write and release-to-ack-drop latency. data0/data1 are still sampled directly, which is safe because of bundled-data stability.
- Undefined: reqN_s=reqN; requesters must be synchronous to clk.

Decomposition:
- Shared package hs_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_WRITE=2'd1, ST_ACK=2'd2.
  - Default data-width constant HS_DW=8.
- Sub-module hs_sync: 2-flop synchronizer with clk, rst_n, d, q. Instantiated twice under HS_SYNC_EN.

Test Plan:
- Reset: rst_n=0 with req0=1 -> ack0=ack1=wr_en=busy=0, wr_data=0; release -> req0 served first.
- Single transfer: req0=1, data0=8'hA5 -> wr_en=1 for one cycle with wr_data=8'hA5; ack0=1 next cycle; drop req0 -> ack0=0 one cycle later, busy=0.
- Contention: req0=req1=1, data0=8'h11, data1=8'h22 -> writes 8'h11 then 8'h22 in order. Repeating both requests -> order 11,22,11,22.
- Full: fifo_full=1, req1=1 -> no wr_en and no ack1 for 10 cycles; fifo_full=0 -> one write of data1, then ack1.
- Mid-transfer reset: assert rst_n=0 while ack0=1 -> ack0 drops asynchronously, FSM in IDLE; no second write after release until req0 goes 0 then 1.
- HS_SYNC_EN build: repeat the single-transfer case -> wr_en appears 2 cycles later than in the non-synchronized build.
